fifo_rd_ctrl: RTL and testbench
===============================

// Module: fifo_rd_ctrl
// PURPOSE
//   Read-side controller for the 2x10-entry, 8-bit positive-edge FIFO. It pairs
//   with the write-side pointer counter: it owns the read pointer and detects
//   empty by comparing against the write pointer. It fetches from the storage
//   array and presents data on a registered valid/ready output stage.
//   Same clock domain as the write side, so no pointer synchronisation.
// PARAMETERS
//   DATA_W  8   data width
//   DEPTH   20  storage entries (2 banks x 10)
//   ADDR_W  5   address width, ceil(log2(DEPTH))
// PORTS
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous reset, active low
//   wr_ptr     in   ADDR_W+1  write pointer {lap, addr} from write side
//   flush      in   1         sync discard of all unread data
//   mem_raddr  out  ADDR_W    storage read address (combinational read)
//   mem_rdata  in   DATA_W    storage data at mem_raddr, same cycle
//   rd_ptr     out  ADDR_W+1  read pointer {lap, addr}, returned to write side
//   m_valid    out  1         output data valid
//   m_ready    in   1         consumer accepts m_data
//   m_data     out  DATA_W    output data register
//   empty      out  1         storage holds no unread entry
//   level      out  ADDR_W+1  entries resident in storage (excludes m_data reg)
// BEHAVIOUR
//   - Reset (async, rst_n=0): rd_ptr=0, m_valid=0, m_data=0. Combinational
//     outputs follow rd_ptr=0, so level=wr_ptr distance from 0.
//   - Pointer format: addr counts 0..DEPTH-1. Increment from DEPTH-1 wraps addr
//     to 0 and toggles lap.
//   - empty = (rd_ptr == wr_ptr). Full detection belongs to the write side:
//     same addr, different lap.
//   - level = (lap equal) ? wr.addr-rd.addr : DEPTH-rd.addr+wr.addr.
//     Range 0..DEPTH.
//   - mem_raddr = rd_ptr.addr, combinational.
//   - load = !empty && (!m_valid || m_ready). On load: m_data<=mem_rdata,
//     m_valid<=1, rd_ptr<=rd_ptr+1.
//   - Consume without load (m_valid && m_ready && empty): m_valid<=0.
//   - m_valid && !m_ready: hold m_data and rd_ptr. Never drop or repeat data.
//   - Throughput: 1 word/cycle while !empty and m_ready=1.
//   - Latency: wr_ptr advance at edge N (empty->non-empty) gives m_valid=1
//     after edge N+1.
//   - flush=1: rd_ptr<=wr_ptr, m_valid<=0. Flush beats load and consume.
//     m_data keeps its value.
//   - Wrap: addr 19 -> 0 with lap toggle. Empty/level stay correct across
//     any number of laps.
//   - rst_n asserted mid-transfer clears immediately. After release, the first
//     rising edge obeys the normal rules.
//   - A wr_ptr giving level > DEPTH is illegal input. Behaviour is undefined
//     and must not hang the state.
// CONFIGURATION
//   FIFO_RD_LEVEL_EN defined: level is driven as above.
//   Undefined: level tied to 0 and no level arithmetic is synthesised.
//   All other behaviour is identical in both builds.
// TESTING
//   1 Reset: rst_n=0, wr_ptr=3 -> rd_ptr=0, m_valid=0, m_data=0, empty=0,
//     level=3 (LEVEL_EN).
//   2 Streaming: mem holds 0x11,0x22,0x33 at 0..2, wr_ptr=3, m_ready=1 ->
//     m_data 0x11,0x22,0x33 on consecutive cycles, then m_valid=0,
//     rd_ptr=3, empty=1.
//   3 Backpressure: m_ready=0 for 4 cycles with 2 entries stored ->
//     m_data=first word held, rd_ptr advanced by exactly 1, level=1.
//   4 Wrap: rd_ptr=19 (lap0), wr_ptr={1,2} -> level=3. Reads return addr
//     19,0,1, then rd_ptr={1,2} and empty=1.
//   5 Flush: level=7, m_valid=1, flush=1 with m_ready=1 -> next cycle
//     rd_ptr=wr_ptr, m_valid=0, level=0.
//   6 Build without FIFO_RD_LEVEL_EN: rerun 2 and 4 -> identical data,
//     level=0 throughout.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the 2x10-entry, 8-bit FIFO.
// Owns the read pointer {lap, addr}, detects empty against the write pointer,
// fetches from the storage array and drives a registered valid/ready stage.
// Optional build macro FIFO_RD_LEVEL_EN: when defined, `level` reports the
// number of entries resident in storage; when undefined, `level` is tied to 0.
module fifo_rd_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 20,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W:0]   wr_ptr,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   rd_ptr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              rd_lap;
    logic [ADDR_W-1:0] rd_addr;
    logic              load;

    assign rd_lap    = rd_ptr_q[ADDR_W];
    assign rd_addr   = rd_ptr_q[ADDR_W-1:0];
    assign mem_raddr = rd_addr;
    assign rd_ptr    = rd_ptr_q;
    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign empty     = (rd_ptr_q == wr_ptr);
    assign load      = !empty && (!m_valid_q || m_ready);

    // Pointer successor: the address wraps at DEPTH-1 and the lap bit toggles.
    always_comb begin
        if (rd_addr == LAST_ADDR) begin
            rd_ptr_inc = {~rd_lap, {ADDR_W{1'b0}}};
        end else begin
            rd_ptr_inc = {rd_lap, rd_addr + ADDR_W'(1)};
        end
    end

    // Output-stage next state: flush beats load, load beats a bare consume.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (flush) begin
            rd_ptr_d  = wr_ptr;
            m_valid_d = 1'b0;
        end else if (load) begin
            rd_ptr_d  = rd_ptr_inc;
            m_valid_d = 1'b1;
            m_data_d  = mem_rdata;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_W:0] wr_addr_x, rd_addr_x;

    assign wr_addr_x = {1'b0, wr_ptr[ADDR_W-1:0]};
    assign rd_addr_x = {1'b0, rd_addr};

    // Occupancy: plain difference on the same lap, otherwise add one lap of DEPTH.
    always_comb begin
        if (wr_ptr[ADDR_W] == rd_lap) begin
            level = wr_addr_x - rd_addr_x;
        end else begin
            level = (ADDR_W + 1)'(DEPTH) - rd_addr_x + wr_addr_x;
        end
    end
`else
    assign level = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a linear-index reference model.
module tb_fifo_rd_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 20;
    localparam int unsigned AW    = 5;
    localparam int unsigned LAPS  = 2 * DEPTH;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic [AW:0]   wr_ptr;
    logic          flush   = 1'b0;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [AW:0]   rd_ptr;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          empty;
    logic [AW:0]   level;

    logic [DW-1:0] mem [DEPTH];
    int unsigned   wcount = 0;   // write position as a linear index 0..2*DEPTH-1

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;

    // Reference model state: read position as a linear index, plus output stage.
    int unsigned   m_r       = 0;
    logic          m_valid_e = 1'b0;
    logic [DW-1:0] m_data_e  = '0;

    fifo_rd_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_ptr    (wr_ptr),
        .flush     (flush),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .rd_ptr    (rd_ptr),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .empty     (empty),
        .level     (level)
    );

    always #5 clk = ~clk;

    function automatic logic [AW:0] to_ptr(input int unsigned idx);
        if (idx >= DEPTH) return {1'b1, AW'(idx - DEPTH)};
        else              return {1'b0, AW'(idx)};
    endfunction

    function automatic int unsigned lvl(input int unsigned v);
`ifdef FIFO_RD_LEVEL_EN
        return v;
`else
        return 0;
`endif
    endfunction

    assign wr_ptr    = to_ptr(wcount);
    assign mem_rdata = mem[mem_raddr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each word read exactly once, in write order, as linear indices.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r       <= 0;
            m_valid_e <= 1'b0;
            m_data_e  <= '0;
        end else if (flush) begin
            m_r       <= wcount;
            m_valid_e <= 1'b0;
        end else if ((m_r != wcount) && (!m_valid_e || m_ready)) begin
            m_data_e  <= mem[m_r % DEPTH];
            m_valid_e <= 1'b1;
            m_r       <= (m_r + 1) % LAPS;
        end else if (m_valid_e && m_ready) begin
            m_valid_e <= 1'b0;
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        chk("rd_ptr",    rd_ptr,    to_ptr(m_r));
        chk("m_valid",   m_valid,   m_valid_e);
        chk("m_data",    m_data,    m_data_e);
        chk("empty",     empty,     (m_r == wcount));
        chk("level",     level,     lvl((wcount + LAPS - m_r) % LAPS));
        chk("mem_raddr", mem_raddr, m_r % DEPTH);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

        // Reset with three words already written
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        wcount  = 3;
        m_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("t1_rd_ptr",  rd_ptr,  0);
        chk("t1_m_valid", m_valid, 0);
        chk("t1_m_data",  m_data,  0);
        chk("t1_empty",   empty,   0);
        chk("t1_level",   level,   lvl(3));
        @(negedge clk); #1 rst_n = 1'b1;

        // Streaming
        @(negedge clk);
        chk("t2_d0", m_data, 8'h11); chk("t2_v0", m_valid, 1);
        @(negedge clk);
        chk("t2_d1", m_data, 8'h22); chk("t2_v1", m_valid, 1);
        @(negedge clk);
        chk("t2_d2", m_data, 8'h33); chk("t2_v2", m_valid, 1);
        @(negedge clk);
        chk("t2_vend", m_valid, 0); chk("t2_rd_ptr", rd_ptr, 3); chk("t2_empty", empty, 1);

        // Backpressure with two entries stored
        #1;
        mem[3] = 8'h44; mem[4] = 8'h55; wcount = 5; m_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold_data", m_data, 8'h44);
            chk("t3_hold_v",    m_valid, 1);
            chk("t3_hold_ptr",  rd_ptr, 4);
            chk("t3_hold_lvl",  level, lvl(1));
        end
        #1 m_ready = 1'b1;
        @(negedge clk);
        chk("t3_d1", m_data, 8'h55); chk("t3_ptr", rd_ptr, 5);
        @(negedge clk);
        chk("t3_vend", m_valid, 0);

        // Wrap: park the read pointer at addr 19 via flush, then span the lap
        #1 wcount = 19; flush = 1'b1;
        @(negedge clk);
        chk("t4_park_ptr", rd_ptr, 19); chk("t4_park_empty", empty, 1); chk("t4_park_v", m_valid, 0);
        #1;
        flush = 1'b0;
        mem[19] = 8'hA0; mem[0] = 8'hA1; mem[1] = 8'hA2;
        wcount = 22;
        #1;
        chk("t4_level", level, lvl(3));
        @(negedge clk);
        chk("t4_d0", m_data, 8'hA0); chk("t4_ptr0", rd_ptr, 6'd32);
        @(negedge clk);
        chk("t4_d1", m_data, 8'hA1);
        @(negedge clk);
        chk("t4_d2", m_data, 8'hA2); chk("t4_ptr2", rd_ptr, 6'd34);
        @(negedge clk);
        chk("t4_vend", m_valid, 0); chk("t4_empty", empty, 1); chk("t4_ptr_end", rd_ptr, 6'd34);

        // Flush with data pending in both storage and the output register
        #1;
        m_ready = 1'b0;
        for (int i = 2; i < 10; i++) mem[i] = 8'(8'h50 + i);
        wcount = 30;
        @(negedge clk);
        chk("t5_pre_level", level, lvl(7)); chk("t5_pre_v", m_valid, 1); chk("t5_pre_d", m_data, 8'h52);
        #1 flush = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        chk("t5_ptr", rd_ptr, 6'd42); chk("t5_v", m_valid, 0); chk("t5_level", level, lvl(0));
        chk("t5_empty", empty, 1); chk("t5_data_kept", m_data, 8'h52);
        #1 flush = 1'b0;

        // Randomized traffic, occasional flush and mid-transfer reset
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                rst_n  = 1'b0;
                wcount = 0;
                flush  = 1'b0;
            end
            if (rst_n) begin
                flush = ($urandom_range(0, 39) == 0);
                if ((i % 1000) < 500) m_ready = ($urandom_range(0, 3) != 0);
                else                  m_ready = ($urandom_range(0, 3) == 0);
                if ((((wcount + LAPS - m_r) % LAPS) < DEPTH) && ($urandom_range(0, 2) != 0)) begin
                    mem[wcount % DEPTH] = 8'($urandom);
                    wcount = (wcount + 1) % LAPS;
                end
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
